// File: rtl/sprite_pos_ctrl.sv
// Sprite position controller: once per frame (on the falling edge of vsync)
// samples the movement request, steps the sprite in x then y with clamping
// at the screen borders, and commits the new position when enabled.
module sprite_pos_ctrl #(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int SPR_W    = 32,
    parameter int SPR_H    = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vsync,
    input  logic        enable,
    input  logic [3:0]  dir,
    input  logic [3:0]  speed,
    output logic [10:0] sprite_x,
    output logic [10:0] sprite_y,
    output logic        upd_strobe,
    output logic [3:0]  edge_hit,
    output logic [15:0] frame_cnt,
    output logic        overrun
);

    localparam logic signed [11:0] X_MAX   = 12'(SCREEN_W - SPR_W);
    localparam logic signed [11:0] Y_MAX   = 12'(SCREEN_H - SPR_H);
    localparam logic [10:0]        X_LIM   = 11'(SCREEN_W - SPR_W);
    localparam logic [10:0]        Y_LIM   = 11'(SCREEN_H - SPR_H);
    localparam logic [10:0]        X_RESET = 11'((SCREEN_W - SPR_W) / 2);
    localparam logic [10:0]        Y_RESET = 11'((SCREEN_H - SPR_H) / 2);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        MOVE_X,
        MOVE_Y,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic        vs_meta;
    logic        vs_sync;
    logic        vs_prev;
    logic        vs_fall;

    logic [3:0]  shd_dir;
    logic [3:0]  shd_speed;
    logic        shd_en;

    logic [10:0] work_x;
    logic [10:0] work_y;
    logic [1:0]  flag_lr;
    logic [1:0]  flag_tb;

    logic signed [11:0] step;
    logic signed [11:0] x_calc;
    logic signed [11:0] y_calc;
    logic [10:0] x_res;
    logic [10:0] y_res;
    logic [1:0]  x_flg;
    logic [1:0]  y_flg;

    // Bring vsync into this clock domain and keep one extra stage for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_meta <= 1'b1;
            vs_sync <= 1'b1;
            vs_prev <= 1'b1;
        end else begin
            vs_meta <= vsync;
            vs_sync <= vs_meta;
            vs_prev <= vs_sync;
        end
    end

    assign vs_fall = vs_prev & ~vs_sync;

    // Frame sequencer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Frame sequencer next state: one cycle per step once a frame starts
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (vs_fall) state_nxt = LATCH;
            LATCH:   state_nxt = MOVE_X;
            MOVE_X:  state_nxt = MOVE_Y;
            MOVE_Y:  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Candidate positions from the committed position and the latched request, with border clamping
    always_comb begin
        step   = $signed({8'd0, shd_speed});
        x_calc = $signed({1'b0, sprite_x});
        y_calc = $signed({1'b0, sprite_y});
        if (shd_dir[1] && !shd_dir[0]) begin
            x_calc = $signed({1'b0, sprite_x}) - step;
        end else if (shd_dir[0] && !shd_dir[1]) begin
            x_calc = $signed({1'b0, sprite_x}) + step;
        end
        if (shd_dir[3] && !shd_dir[2]) begin
            y_calc = $signed({1'b0, sprite_y}) - step;
        end else if (shd_dir[2] && !shd_dir[3]) begin
            y_calc = $signed({1'b0, sprite_y}) + step;
        end
        x_res = x_calc[10:0];
        x_flg = 2'b00;
        if (x_calc <= 12'sd0) begin
            x_res = 11'd0;
            x_flg = 2'b10;
        end else if (x_calc >= X_MAX) begin
            x_res = X_LIM;
            x_flg = 2'b01;
        end
        y_res = y_calc[10:0];
        y_flg = 2'b00;
        if (y_calc <= 12'sd0) begin
            y_res = 11'd0;
            y_flg = 2'b10;
        end else if (y_calc >= Y_MAX) begin
            y_res = Y_LIM;
            y_flg = 2'b01;
        end
    end

    // Per-frame datapath: latch request, compute x then y, commit when the frame was enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shd_dir    <= 4'd0;
            shd_speed  <= 4'd0;
            shd_en     <= 1'b0;
            work_x     <= X_RESET;
            work_y     <= Y_RESET;
            flag_lr    <= 2'b00;
            flag_tb    <= 2'b00;
            sprite_x   <= X_RESET;
            sprite_y   <= Y_RESET;
            upd_strobe <= 1'b0;
            edge_hit   <= 4'd0;
            frame_cnt  <= 16'd0;
            overrun    <= 1'b0;
        end else begin
            upd_strobe <= 1'b0;
            if (vs_fall && state != IDLE) begin
                overrun <= 1'b1;
            end
            if (state == IDLE && vs_fall) begin
                shd_dir   <= dir;
                shd_speed <= speed;
                shd_en    <= enable;
            end
            if (state == LATCH) begin
                work_x  <= x_res;
                flag_lr <= x_flg;
            end
            if (state == MOVE_X) begin
                work_y  <= y_res;
                flag_tb <= y_flg;
            end
            if (state == MOVE_Y && shd_en) begin
                sprite_x   <= work_x;
                sprite_y   <= work_y;
                edge_hit   <= {flag_tb, flag_lr};
                frame_cnt  <= frame_cnt + 16'd1;
                upd_strobe <= 1'b1;
            end
        end
    end

endmodule
